// File: rtl/mix_pkg.sv
// Shared types and constants for the serial lane-mixing engine.
// The MIX_XORSHIFT_EN build option uses XSHIFT as its shift distance.
package mix_pkg;

    localparam int NLANES = 8;
    localparam int XSHIFT = 16;

    typedef enum logic [1:0] {
        LOAD,
        RUN,
        FINAL,
        DRAIN
    } state_t;

    localparam int unsigned MUL [NLANES] = '{2, 3, 5, 7, 11, 13, 17, 19};
    localparam int unsigned ADD [NLANES] = '{3, 5, 7, 11, 13, 17, 19, 23};

endpackage

// File: rtl/mix_lane_step.sv
// Combinational lane-step function for one RUN cycle.
// With MIX_XORSHIFT_EN defined, the lane three ahead is shifted and XORed in.
module mix_lane_step
    import mix_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [W-1:0] cur,
    input  logic [W-1:0] prev1,
    input  logic [W-1:0] prev2,
`ifdef MIX_XORSHIFT_EN
    input  logic [W-1:0] ahead3,
`endif
    output logic [W-1:0] result
);

`ifdef MIX_XORSHIFT_EN
    assign result = (cur + prev1 - prev2) ^ (ahead3 << XSHIFT);
`else
    assign result = cur + prev1 - prev2;
`endif

endmodule

// File: rtl/mix_stream_engine.sv
// Serial 8-lane mixer: load seed, ROUNDS lane-chained mix passes, final mul-add, drain.
// Build option MIX_XORSHIFT_EN selects the xorshift variant of the RUN step.
module mix_stream_engine
    import mix_pkg::*;
#(
    parameter int W      = 32,
    parameter int ROUNDS = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         out_last,
    output logic         busy
);

    // Wide enough to count up to ROUNDS-1 even when ROUNDS is 0 or 1.
    localparam int RW = $clog2(ROUNDS + 2);

    state_t         state;
    logic [2:0]     idx;
    logic [RW-1:0]  rnd;
    logic [W-1:0]   lane [NLANES];
    logic [W-1:0]   fin  [NLANES];
    logic [W-1:0]   step_val;

    // Lane indices wrap mod 8 through natural 3-bit arithmetic.
    mix_lane_step #(.W(W)) u_step (
        .cur    (lane[idx]),
        .prev1  (lane[idx - 3'd1]),
        .prev2  (lane[idx - 3'd2]),
`ifdef MIX_XORSHIFT_EN
        .ahead3 (lane[idx + 3'd3]),
`endif
        .result (step_val)
    );

    always_comb begin
        for (int i = 0; i < NLANES; i++) begin
            fin[i] = lane[i] * W'(MUL[i]) + W'(ADD[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= LOAD;
            idx       <= '0;
            rnd       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            out_data  <= '0;
            for (int i = 0; i < NLANES; i++) begin
                lane[i] <= '0;
            end
        end else begin
            case (state)
                LOAD: begin
                    if (in_valid && in_ready) begin
                        lane[idx] <= in_data;
                        idx       <= idx + 3'd1;
                        if (idx == 3'd7) begin
                            in_ready <= 1'b0;
                            busy     <= 1'b1;
                            state    <= (ROUNDS == 0) ? FINAL : RUN;
                        end
                    end
                end

                RUN: begin
                    lane[idx] <= step_val;
                    idx       <= idx + 3'd1;
                    if (idx == 3'd7) begin
                        if (int'(rnd) == ROUNDS - 1) begin
                            rnd   <= '0;
                            state <= FINAL;
                        end else begin
                            rnd <= rnd + 1'b1;
                        end
                    end
                end

                FINAL: begin
                    for (int i = 0; i < NLANES; i++) begin
                        lane[i] <= fin[i];
                    end
                    // Present lane 0 straight away so DRAIN starts with valid data.
                    out_data  <= fin[0];
                    out_valid <= 1'b1;
                    out_last  <= 1'b0;
                    busy      <= 1'b0;
                    idx       <= '0;
                    state     <= DRAIN;
                end

                DRAIN: begin
                    if (out_ready) begin
                        if (idx == 3'd7) begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            out_data  <= '0;
                            in_ready  <= 1'b1;
                            idx       <= '0;
                            rnd       <= '0;
                            state     <= LOAD;
                            for (int i = 0; i < NLANES; i++) begin
                                lane[i] <= '0;
                            end
                        end else begin
                            idx      <= idx + 3'd1;
                            out_data <= lane[idx + 3'd1];
                            out_last <= (idx == 3'd6);
                        end
                    end
                end

                default: state <= LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_mix_stream_engine.sv
// Self-checking bench for mix_stream_engine: three instances (ROUNDS 0, 1, 4) against a block-level model.
// Honours MIX_XORSHIFT_EN in the model when the bench is built with it.
module tb_mix_stream_engine;

    typedef logic [31:0] blk_t [8];

    localparam int RND [3] = '{0, 1, 4};
    localparam int unsigned M_MUL [8] = '{2, 3, 5, 7, 11, 13, 17, 19};
    localparam int unsigned M_ADD [8] = '{3, 5, 7, 11, 13, 17, 19, 23};

    logic        clk;
    logic        rst_n;
    logic        in_valid  [3];
    logic        in_ready  [3];
    logic [31:0] in_data   [3];
    logic        out_valid [3];
    logic        out_ready [3];
    logic [31:0] out_data  [3];
    logic        out_last  [3];
    logic        busy      [3];

    int checks;
    int failures;

    logic [31:0] expm [3][32];
    int          wr [3];
    int          rd [3];
    logic        ready_toggle [3];
    logic        stall_prev [3];
    logic [31:0] data_prev [3];

    mix_stream_engine #(.W(32), .ROUNDS(0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
        .out_last(out_last[0]), .busy(busy[0])
    );

    mix_stream_engine #(.W(32), .ROUNDS(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
        .out_last(out_last[1]), .busy(busy[1])
    );

    mix_stream_engine #(.W(32), .ROUNDS(4)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_data(in_data[2]),
        .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_data(out_data[2]),
        .out_last(out_last[2]), .busy(busy[2])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Whole-block model: run the mix passes on an array, then the mul-add stage.
    function automatic void model(input blk_t seed, input int rounds, output blk_t res);
        blk_t a;
        a = seed;
        for (int r = 0; r < rounds; r++) begin
            for (int i = 0; i < 8; i++) begin
`ifdef MIX_XORSHIFT_EN
                a[i] = (a[i] + a[(i + 7) % 8] - a[(i + 6) % 8]) ^ (a[(i + 3) % 8] << 16);
`else
                a[i] = a[i] + a[(i + 7) % 8] - a[(i + 6) % 8];
`endif
            end
        end
        for (int i = 0; i < 8; i++) begin
            res[i] = a[i] * M_MUL[i] + M_ADD[i];
        end
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic reportTimeout(input string name);
        checks++;
        failures++;
        $display("[TB] FAIL %s timed out at %0t", name, $time);
    endtask

    // Loads one seed block into instance k and records the model's result words.
    task automatic applyStimulus(input int k, input blk_t seed, output int stalls);
        blk_t res;
        logic ok;
        int   guard;
        stalls = 0;
        for (int j = 0; j < 8; j++) begin
            in_valid[k] = 1'b1;
            in_data[k]  = seed[j];
            guard = 0;
            ok    = 1'b0;
            while (!ok && guard < 500) begin
                @(negedge clk);
                ok = in_ready[k];
                @(posedge clk);
                #1;
                if (!ok) stalls++;
                guard++;
            end
            if (!ok) reportTimeout($sformatf("d%0d_load_beat%0d", k, j));
        end
        in_valid[k] = 1'b0;
        model(seed, RND[k], res);
        for (int i = 0; i < 8; i++) begin
            expm[k][wr[k] % 32] = res[i];
            wr[k]++;
        end
    endtask

    // Called right after the last seed beat: checks latency and busy duration.
    task automatic measureRun(input int k);
        int lat;
        int bcnt;
        lat  = 0;
        bcnt = 0;
        while (lat < 200) begin
            if (busy[k]) bcnt++;
            if (out_valid[k]) break;
            @(posedge clk);
            #1;
            lat++;
        end
        if (lat >= 200) reportTimeout($sformatf("d%0d_first_valid", k));
        checkOutput($sformatf("d%0d_latency", k), lat, RND[k] * 8 + 1);
        checkOutput($sformatf("d%0d_busy_cycles", k), bcnt, RND[k] * 8 + 1);
    endtask

    task automatic waitDrained(input int k);
        int guard;
        guard = 0;
        while ((wr[k] != rd[k] || out_valid[k]) && guard < 300) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (guard >= 300) reportTimeout($sformatf("d%0d_drain", k));
        checkOutput($sformatf("d%0d_idle_valid", k), out_valid[k], 0);
        checkOutput($sformatf("d%0d_idle_ready", k), in_ready[k], 1);
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid[k] = 1'b0;
            wr[k] = 0;
            rd[k] = 0;
        end
        #1;
        for (int k = 0; k < 3; k++) begin
            checkOutput($sformatf("d%0d_rst_in_ready", k), in_ready[k], 1);
            checkOutput($sformatf("d%0d_rst_out_valid", k), out_valid[k], 0);
            checkOutput($sformatf("d%0d_rst_out_last", k), out_last[k], 0);
            checkOutput($sformatf("d%0d_rst_busy", k), busy[k], 0);
            checkOutput($sformatf("d%0d_rst_out_data", k), out_data[k], 0);
        end
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Sink handshake driver: always ready, or alternating when toggling is enabled.
    initial begin
        for (int k = 0; k < 3; k++) out_ready[k] = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            for (int k = 0; k < 3; k++) begin
                out_ready[k] = ready_toggle[k] ? ~out_ready[k] : 1'b1;
            end
        end
    end

    // Per-cycle compare of every instance's output stream against the scoreboard.
    initial begin
        for (int k = 0; k < 3; k++) begin
            stall_prev[k] = 1'b0;
            data_prev[k]  = '0;
        end
        forever begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                if (!rst_n) begin
                    stall_prev[k] = 1'b0;
                end else begin
                    if (stall_prev[k]) begin
                        checkOutput($sformatf("d%0d_stall_hold", k), out_data[k], data_prev[k]);
                    end
                    if (out_valid[k]) begin
                        checkOutput($sformatf("d%0d_in_ready_drain", k), in_ready[k], 0);
                        if (wr[k] == rd[k]) begin
                            checkOutput($sformatf("d%0d_spurious_valid", k), out_valid[k], 0);
                        end else begin
                            checkOutput($sformatf("d%0d_data%0d", k, rd[k] % 8), out_data[k], expm[k][rd[k] % 32]);
                            checkOutput($sformatf("d%0d_last%0d", k, rd[k] % 8), out_last[k], (rd[k] % 8) == 7);
                            if (out_ready[k]) rd[k]++;
                        end
                    end
                    stall_prev[k] = out_valid[k] && !out_ready[k];
                    data_prev[k]  = out_data[k];
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL global_watchdog expired at %0t", $time);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        blk_t seq, one, zero, alt, res, lit;
        int   stalls;

        checks   = 0;
        failures = 0;
        for (int k = 0; k < 3; k++) begin
            in_valid[k]     = 1'b0;
            in_data[k]      = '0;
            ready_toggle[k] = 1'b0;
            wr[k] = 0;
            rd[k] = 0;
        end
        seq  = '{0, 1, 2, 3, 4, 5, 6, 7};
        one  = '{1, 0, 0, 0, 0, 0, 0, 0};
        zero = '{0, 0, 0, 0, 0, 0, 0, 0};
        alt  = '{32'hDEADBEEF, 32'h12345678, 32'hFFFFFFFF, 32'h80000000,
                 32'h00000001, 32'hCAFEF00D, 32'h0F0F0F0F, 32'h7FFFFFFF};

        rst_n = 1'b0;
        #12;
        doReset();

        // Pin the model itself to hand-computed results.
        model(seq, 0, res);
        lit = '{3, 8, 17, 32, 57, 82, 121, 156};
        for (int i = 0; i < 8; i++) checkOutput($sformatf("model_r0_seq%0d", i), res[i], lit[i]);
        model(zero, 1, res);
        lit = '{3, 5, 7, 11, 13, 17, 19, 23};
        for (int i = 0; i < 8; i++) checkOutput($sformatf("model_r1_zero%0d", i), res[i], lit[i]);
`ifndef MIX_XORSHIFT_EN
        model(one, 1, res);
        lit = '{5, 8, 7, 4, 2, 17, 36, 42};
        for (int i = 0; i < 8; i++) checkOutput($sformatf("model_r1_one%0d", i), res[i], lit[i]);
`endif

        $display("[TB] ROUNDS=0 seed 0..7");
        applyStimulus(0, seq, stalls);
        measureRun(0);
        waitDrained(0);

        $display("[TB] ROUNDS=1 single-one seed");
        applyStimulus(1, one, stalls);
        measureRun(1);
        waitDrained(1);

        $display("[TB] ROUNDS=1 all-zero seed");
        applyStimulus(1, zero, stalls);
        measureRun(1);
        waitDrained(1);

        $display("[TB] ROUNDS=4 mixed seed");
        applyStimulus(2, alt, stalls);
        measureRun(2);
        waitDrained(2);

        $display("[TB] ROUNDS=0 drain with toggling out_ready");
        ready_toggle[0] = 1'b1;
        applyStimulus(0, seq, stalls);
        waitDrained(0);
        ready_toggle[0] = 1'b0;
        @(posedge clk);
        #1;

        $display("[TB] reset during RUN");
        applyStimulus(2, alt, stalls);
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        checkOutput("d2_busy_before_abort", busy[2], 1);
        doReset();

        $display("[TB] reset after third drain beat");
        applyStimulus(1, alt, stalls);
        begin
            int guard;
            guard = 0;
            while (rd[1] < 3 && guard < 100) begin
                @(posedge clk);
                #1;
                guard++;
            end
            if (guard >= 100) reportTimeout("d1_three_beats");
        end
        doReset();

        $display("[TB] post-reset ROUNDS=0 load");
        applyStimulus(0, seq, stalls);
        measureRun(0);
        waitDrained(0);
        applyStimulus(1, one, stalls);
        waitDrained(1);

        $display("[TB] back-to-back blocks");
        applyStimulus(0, alt, stalls);
        applyStimulus(0, seq, stalls);
        checkOutput("d0_b2b_stall_cycles", stalls, 9);
        waitDrained(0);
        applyStimulus(2, zero, stalls);
        applyStimulus(2, one, stalls);
        waitDrained(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
